// File: rtl/simd_pkg.sv
// Shared SIMD array geometry, result-row type and result-drain FSM state encoding.
package simd_pkg;
  localparam int PE_COUNT   = 4;
  localparam int DATA_WIDTH = 32;
  localparam int BRAM_DEPTH = 2048;
  localparam int ADDR_WIDTH = $clog2(BRAM_DEPTH);

  typedef logic [PE_COUNT-1:0][DATA_WIDTH-1:0] row_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_FLUSH
  } drain_state_t;
endpackage

// File: rtl/drain_fifo.sv
// Small synchronous FIFO with combinational head read; push on full and pop on empty are dropped.
module drain_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_next(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_next(rd_ptr);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/result_drain.sv
// Streams a run of result-BRAM rows out on a valid/ready port, issuing reads only
// when the landing FIFO is guaranteed room, so m_ready may stall indefinitely.
module result_drain #(
  parameter int PE_COUNT   = simd_pkg::PE_COUNT,
  parameter int DATA_WIDTH = simd_pkg::DATA_WIDTH,
  parameter int BRAM_DEPTH = simd_pkg::BRAM_DEPTH,
  parameter int RD_LATENCY = 2,
  localparam int ADDR_WIDTH = $clog2(BRAM_DEPTH),
  localparam int ROW_W      = PE_COUNT * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   row_count,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic                  bram_en,
  input  logic [ROW_W-1:0]      bram_dout,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [ROW_W-1:0]      m_data,
  output logic                  m_last,
  output logic                  busy,
  output logic                  done
);
  import simd_pkg::drain_state_t;
  import simd_pkg::S_IDLE;
  import simd_pkg::S_READ;
  import simd_pkg::S_FLUSH;

  localparam int FIFO_DEPTH = RD_LATENCY + 2;
  localparam int FCW        = $clog2(FIFO_DEPTH + 1);
  localparam int CW         = $clog2(2 * RD_LATENCY + 3);
  localparam int NW         = ADDR_WIDTH + 1;

  drain_state_t          state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr;
  logic [NW-1:0]         remaining;
  logic [RD_LATENCY-1:0] vld_pipe;
  logic [RD_LATENCY-1:0] last_pipe;
  logic                  done_q;
  logic [CW-1:0]         in_flight;
  logic [CW-1:0]         occupancy;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic [FCW-1:0]        fifo_count;
  logic [ROW_W:0]        fifo_head;
  logic                  issue;
  logic                  issue_last;
  logic                  xfer;
  logic                  xfer_last;
  logic                  start_rows;

  // Every issued-but-unconsumed row owns a FIFO slot, so pushes can never overflow.
  always_comb begin
    in_flight = '0;
    for (int i = 0; i < RD_LATENCY; i++) in_flight = in_flight + CW'(vld_pipe[i]);
  end

  assign occupancy  = in_flight + CW'(fifo_count);
  assign issue      = (state == S_READ) && !fifo_full && (occupancy < CW'(FIFO_DEPTH));
  assign issue_last = issue && (remaining == NW'(1));
  assign start_rows = start && (row_count != '0);

  assign m_valid   = !fifo_empty;
  assign m_data    = fifo_head[ROW_W-1:0];
  assign m_last    = m_valid && fifo_head[ROW_W];
  assign xfer      = m_valid && m_ready;
  assign xfer_last = xfer && m_last;

  assign bram_en   = issue;
  assign bram_addr = addr;
  assign busy      = (state != S_IDLE);
  assign done      = done_q;

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (start_rows) state_nxt = S_READ;
      S_READ:  if (issue_last) state_nxt = S_FLUSH;
      S_FLUSH: if (xfer_last)  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state     <= S_IDLE;
      addr      <= '0;
      remaining <= '0;
      vld_pipe  <= '0;
      last_pipe <= '0;
      done_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= xfer_last || ((state == S_IDLE) && start && (row_count == '0));
      vld_pipe[0]  <= issue;
      last_pipe[0] <= issue_last;
      for (int i = 1; i < RD_LATENCY; i++) begin
        vld_pipe[i]  <= vld_pipe[i-1];
        last_pipe[i] <= last_pipe[i-1];
      end
      if ((state == S_IDLE) && start_rows) begin
        addr      <= base_addr;
        remaining <= row_count;
      end else if (issue) begin
        addr      <= (addr == ADDR_WIDTH'(BRAM_DEPTH - 1)) ? '0 : addr + ADDR_WIDTH'(1);
        remaining <= remaining - NW'(1);
      end
    end
  end

  drain_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ROW_W + 1)
  ) u_fifo (
    .clk       (clk),
    .rstn      (rstn),
    .push      (vld_pipe[RD_LATENCY-1]),
    .push_data ({last_pipe[RD_LATENCY-1], bram_dout}),
    .pop       (xfer),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );
endmodule

// File: tb/tb_result_drain.sv
// Directed bench for result_drain against a two-cycle BRAM model whose row a lane j holds 4a+j.
module tb_result_drain;
  logic         clk = 1'b0;
  logic         rstn;
  logic         start;
  logic [10:0]  base_addr;
  logic [11:0]  row_count;
  logic [10:0]  bram_addr;
  logic         bram_en;
  logic [127:0] bram_dout;
  logic         m_valid;
  logic         m_ready;
  logic [127:0] m_data;
  logic         m_last;
  logic         busy;
  logic         done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_base, exp_count, rx, issued, done_cnt, done_cyc, last_cyc, first_vld, vld_seen, start_cyc;
  bit rnd_ready = 1'b0;
  bit prev_stall = 1'b0;
  logic [127:0] prev_data;
  logic prev_last;
  logic [10:0] a1;

  always #5 clk = ~clk;

  result_drain dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .base_addr (base_addr),
    .row_count (row_count),
    .bram_addr (bram_addr),
    .bram_en   (bram_en),
    .bram_dout (bram_dout),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_last    (m_last),
    .busy      (busy),
    .done      (done)
  );

  function automatic logic [127:0] row_of(input logic [10:0] a);
    logic [127:0] r;
    for (int j = 0; j < 4; j++) r[j*32 +: 32] = 32'(a) * 32'd4 + 32'(j);
    return r;
  endfunction

  // Registered address then registered data: read data valid two cycles after bram_en.
  always @(posedge clk) begin
    if (bram_en === 1'b1) a1 <= bram_addr;
    bram_dout <= row_of(a1);
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rnd_ready) m_ready = 1'($urandom_range(0, 1));
    @(negedge clk);
    cyc++;
    if (prev_stall) begin
      chk("stall_valid", m_valid, 1);
      chk("stall_data", m_data, prev_data);
      chk("stall_last", m_last, prev_last);
    end
    if (bram_en === 1'b1) begin
      chk("credit", (issued - rx) < 4, 1);
      chk("over_issue", issued < exp_count, 1);
      chk("addr", bram_addr, (exp_base + issued) % 2048);
      issued++;
    end
    if (m_valid === 1'b1) begin
      vld_seen++;
      if (first_vld < 0) first_vld = cyc;
      if (m_ready) begin
        chk("extra_row", rx < exp_count, 1);
        chk("data", m_data, row_of(11'((exp_base + rx) % 2048)));
        chk("last", m_last, rx == exp_count - 1);
        if (m_last) last_cyc = cyc;
        rx++;
      end
    end
    if (done === 1'b1) begin
      done_cnt++;
      done_cyc = cyc;
      chk("busy_at_done", busy, 0);
    end
    prev_stall = (m_valid === 1'b1) && !m_ready;
    prev_data  = m_data;
    prev_last  = m_last;
  endtask

  task automatic clear_tracking(input int base, input int cnt);
    exp_base = base; exp_count = cnt; rx = 0; issued = 0; done_cnt = 0;
    done_cyc = -1; last_cyc = -1; first_vld = -1; vld_seen = 0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_bram_en"}, bram_en, 0);
    chk({tag, "_bram_addr"}, bram_addr, 0);
    chk({tag, "_m_valid"}, m_valid, 0);
    chk({tag, "_m_last"}, m_last, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
  endtask

  task automatic drain(input int base, input int cnt, input bit rnd, input int restart_at);
    int n;
    clear_tracking(base, cnt);
    rnd_ready = rnd;
    if (!rnd) m_ready = 1'b1;
    base_addr = 11'(base);
    row_count = 12'(cnt);
    start = 1'b1;
    start_cyc = cyc;
    tick();
    start = 1'b0;
    if (cnt > 0) chk("busy_after_start", busy, 1);
    n = 0;
    while (done_cnt == 0 && n < 2000) begin
      start = (restart_at > 0) && (cyc - start_cyc == restart_at);
      if (start) begin
        base_addr = 11'd500;
        row_count = 12'd3;
      end
      tick();
      start = 1'b0;
      n++;
    end
    rnd_ready = 1'b0;
    m_ready = 1'b1;
    repeat (4) tick();
    chk("rows", rx, cnt);
    chk("issued", issued, cnt);
    chk("done_once", done_cnt, 1);
    if (cnt > 0) begin
      chk("done_after_last", done_cyc, last_cyc + 1);
      chk("idle_after", busy, 0);
    end else begin
      chk("done_zero", done_cyc, start_cyc + 1);
      chk("no_valid", vld_seen, 0);
    end
    if (!rnd && cnt > 0) chk("first_valid", first_vld, start_cyc + 4);
  endtask

  initial begin
    rstn = 1'b0; start = 1'b0; m_ready = 1'b1; base_addr = '0; row_count = '0;
    clear_tracking(0, 0);
    tick();
    tick();
    check_reset_outputs("reset");
    rstn = 1'b1;
    tick();

    drain(0, 75, 1'b0, 0);       // basic full-rate drain
    drain(0, 32, 1'b1, 0);       // random backpressure
    drain(2046, 4, 1'b0, 0);     // address wrap
    drain(7, 0, 1'b0, 0);        // zero rows
    drain(9, 1, 1'b0, 0);        // single row
    drain(100, 20, 1'b0, 5);     // start while busy

    // Reset in the middle of a 40-row drain with reads still in flight.
    clear_tracking(0, 40);
    m_ready = 1'b1;
    base_addr = 11'd0;
    row_count = 12'd40;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int n = 0; n < 500 && rx < 10; n++) tick();
    chk("reach_row10", rx, 10);
    chk("in_flight_at_reset", issued > rx, 1);
    rstn = 1'b0;
    tick();
    check_reset_outputs("mid_reset");
    rstn = 1'b1;
    vld_seen = 0;
    done_cnt = 0;
    repeat (8) tick();
    chk("no_stale_valid", vld_seen, 0);
    chk("no_done_after_reset", done_cnt, 0);
    drain(300, 5, 1'b0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
